// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one pipelined read-only memory port between NUM_REQ masters.
// Each accepted read is tagged in a FIFO so its return beat is steered back to the issuer.
module mem_read_arbiter #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
   input  logic [NUM_REQ-1:0]          req_read,
   output logic [NUM_REQ-1:0]          req_waitrequest,
   output logic [DATA_W-1:0]           req_readdata,
   output logic [NUM_REQ-1:0]          req_readdatavalid,
   output logic [ADDR_W-1:0]           address,
   output logic                        read,
   input  logic [DATA_W-1:0]           readdata,
   input  logic                        readdatavalid,
   input  logic                        waitrequest,
   output logic [$clog2(MAX_OUTST):0]  outstanding,
   output logic                        err_orphan
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned PtrW = $clog2(MAX_OUTST);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTST);
   localparam logic [IdW-1:0]  LastId  = IdW'(NUM_REQ - 1);

   logic             lock_q, lock_d;
   logic [IdW-1:0]   locked_id_q, locked_id_d;
   logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]   tag_q [MAX_OUTST];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             err_q;

   logic [IdW-1:0]   rr_grant, grant, head_tag;
   logic [IdW:0]     scan_idx;
   logic             found;
   logic             tag_full, tag_empty, accept, stall, pop;

   // Rotating priority scan starting at rr_ptr_q.
   always_comb begin
      rr_grant = rr_ptr_q;
      found    = 1'b0;
      scan_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (IdW+1)'(k);
         if (scan_idx >= (IdW+1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (IdW+1)'(NUM_REQ);
         end
         if (!found && req_read[scan_idx[IdW-1:0]]) begin
            found    = 1'b1;
            rr_grant = scan_idx[IdW-1:0];
         end
      end
   end

   assign grant     = lock_q ? locked_id_q : rr_grant;
   assign tag_full  = (cnt_q == CntFull);
   assign tag_empty = (cnt_q == '0);
   assign head_tag  = tag_q[rd_ptr_q];

   assign read   = rst_n & req_read[grant] & ~tag_full;
   assign accept = read & ~waitrequest;
   assign stall  = read & waitrequest;
   assign pop    = rst_n & readdatavalid & ~tag_empty;

   always_comb begin
      address = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant == IdW'(i)) begin
            address = req_address[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_waitrequest[i]   = ~(accept & (grant == IdW'(i)));
         req_readdatavalid[i] = pop & (head_tag == IdW'(i));
      end
   end

   assign req_readdata = readdata;
   assign outstanding  = cnt_q;
   assign err_orphan   = err_q;

   always_comb begin
      lock_d      = lock_q;
      locked_id_d = locked_id_q;
      rr_ptr_d    = rr_ptr_q;
      if (accept) begin
         lock_d   = 1'b0;
         rr_ptr_d = (grant == LastId) ? '0 : grant + 1'b1;
      end else if (stall) begin
         lock_d      = 1'b1;
         locked_id_d = grant;
      end else if (!tag_full) begin
         // Locked master withdrew its request: release without issuing.
         lock_d = 1'b0;
      end
   end

   assign cnt_d = cnt_q + CntW'(accept) - CntW'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q      <= 1'b0;
         locked_id_q <= '0;
         rr_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUTST; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         lock_q      <= lock_d;
         locked_id_q <= locked_id_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         if (accept) begin
            tag_q[wr_ptr_q] <= grant;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (readdatavalid && tag_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   a_rdv_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_readdatavalid));
   a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
      cnt_q <= CntFull);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: a memory model with programmable stall/latency and a
// transaction-level arbitration model predict every command, handshake and return beat.
module tb_mem_read_arbiter;

   localparam int NUM_REQ   = 2;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 64;
   localparam int MAX_OUTST = 4;
   localparam int CntW      = $clog2(MAX_OUTST) + 1;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [NUM_REQ*ADDR_W-1:0] req_address;
   logic [NUM_REQ-1:0]        req_read, req_waitrequest, req_readdatavalid;
   logic [DATA_W-1:0]         req_readdata, readdata;
   logic [ADDR_W-1:0]         address;
   logic                      read, readdatavalid, waitrequest;
   logic [CntW-1:0]           outstanding;
   logic                      err_orphan;

   mem_read_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_address       (req_address),
      .req_read          (req_read),
      .req_waitrequest   (req_waitrequest),
      .req_readdata      (req_readdata),
      .req_readdatavalid (req_readdatavalid),
      .address           (address),
      .read              (read),
      .readdata          (readdata),
      .readdatavalid     (readdatavalid),
      .waitrequest       (waitrequest),
      .outstanding       (outstanding),
      .err_orphan        (err_orphan)
   );

   always #5 clk = ~clk;

   typedef struct { logic [ADDR_W-1:0] addr; int due; } mreq_t;
   typedef struct { int id; logic [DATA_W-1:0] data; } exp_t;

   logic [ADDR_W-1:0] pend_q [NUM_REQ][$];
   mreq_t             mem_q[$];
   exp_t              exp_q[$];

   int checks = 0, errors = 0, cyc = 0;
   int lat_min = 3, lat_max = 3, wr_prob = 0, wr_force = 0;
   bit hold_ret = 1'b0, orphan_req = 1'b0;

   bit                 stalled = 1'b0, err_exp = 1'b0;
   int                 stalled_id = 0, rr_start = 0;
   logic [NUM_REQ-1:0] dut_acc = '0;

   int phase = 0;
   int max_out = 0, read_cnt = 0, first_rd = -1, last_rd = -1;
   int alt_bad = 0, last_ret = -1, hold_cnt = 0, acc1_cyc = -1, acc0_cyc = -1;
   int acc_cnt = 0, first_ret_cyc = -1, fifth_acc_cyc = -1;
   int rdv_cnt [10];

   localparam logic [ADDR_W-1:0] P3Addr1 = 32'h0000_0300;
   localparam logic [ADDR_W-1:0] P3Addr0 = 32'h0000_0308;

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return {a ^ 32'hDEAD_BEEF, ~a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (!(pend_q[0].size() == 0 && pend_q[1].size() == 0 && exp_q.size() == 0 &&
               mem_q.size() == 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s: not idle after %0d cycles", name, budget);
      end
      repeat (2) @(posedge clk);
      #2;
   endtask

   // Requesters and memory: drive inputs 1 time unit after each rising edge.
   initial begin
      logic [ADDR_W-1:0] a_dummy;
      mreq_t             m_dummy;
      req_read = '0; req_address = '0; readdatavalid = 1'b0; readdata = '0; waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (dut_acc[i] && pend_q[i].size() > 0) a_dummy = pend_q[i].pop_front();
            req_read[i] = (pend_q[i].size() > 0);
            req_address[i*ADDR_W +: ADDR_W] = (pend_q[i].size() > 0) ? pend_q[i][0] : '0;
         end
         dut_acc = '0;
         if (wr_force > 0) begin
            waitrequest = 1'b1;
            wr_force--;
         end else begin
            waitrequest = (int'($urandom_range(99)) < wr_prob);
         end
         if (rst_n && !hold_ret && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            readdatavalid = 1'b1;
            readdata      = mem_word(mem_q[0].addr);
            m_dummy       = mem_q.pop_front();
         end else if (rst_n && orphan_req) begin
            readdatavalid = 1'b1;
            readdata      = {$urandom, $urandom};
            orphan_req    = 1'b0;
         end else begin
            readdatavalid = 1'b0;
            readdata      = {$urandom, $urandom};
         end
      end
   end

   // Monitor / scoreboard: sample mid-cycle, predict what the next edge does.
   initial begin
      bit                 full, pread, pacc;
      int                 pg, j, id;
      logic [ADDR_W-1:0]  paddr;
      logic [NUM_REQ-1:0] exp_wr, exp_rdv;
      exp_t               e;
      mreq_t              m;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_read", 64'(read), 64'(0));
            chk("rst_req_waitrequest", 64'(req_waitrequest), 64'({NUM_REQ{1'b1}}));
            chk("rst_req_readdatavalid", 64'(req_readdatavalid), 64'(0));
            chk("rst_outstanding", 64'(outstanding), 64'(0));
            chk("rst_err_orphan", 64'(err_orphan), 64'(0));
            exp_q.delete();
            stalled = 1'b0; rr_start = 0; err_exp = 1'b0; dut_acc = '0;
         end else begin
            full  = (exp_q.size() >= MAX_OUTST);
            pread = 1'b0;
            pg    = 0;
            if (!full) begin
               if (stalled) begin
                  pg    = stalled_id;
                  pread = req_read[pg];
               end else begin
                  for (int k = 0; k < NUM_REQ; k++) begin
                     j = (rr_start + k) % NUM_REQ;
                     if (!pread && req_read[j]) begin
                        pread = 1'b1;
                        pg    = j;
                     end
                  end
               end
            end
            paddr  = req_address[pg*ADDR_W +: ADDR_W];
            pacc   = pread && !waitrequest;
            exp_wr = '1;
            if (pacc) exp_wr[pg] = 1'b0;
            chk("read", 64'(read), 64'(pread));
            if (pread) chk("address", 64'(address), 64'(paddr));
            chk("req_waitrequest", 64'(req_waitrequest), 64'(exp_wr));
            chk("outstanding", 64'(outstanding), 64'(exp_q.size()));
            chk("err_orphan", 64'(err_orphan), 64'(err_exp));

            exp_rdv = '0;
            if (readdatavalid) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  exp_rdv[e.id] = 1'b1;
                  chk("req_readdata", req_readdata, e.data);
               end else begin
                  err_exp = 1'b1;
               end
            end
            if (readdatavalid || req_readdatavalid != '0) begin
               chk("req_readdatavalid", 64'(req_readdatavalid), 64'(exp_rdv));
            end

            if (pread) begin
               if (waitrequest) begin
                  stalled    = 1'b1;
                  stalled_id = pg;
               end else begin
                  stalled  = 1'b0;
                  rr_start = (pg + 1) % NUM_REQ;
                  e.id     = pg;
                  e.data   = mem_word(paddr);
                  exp_q.push_back(e);
               end
            end else if (!full) begin
               stalled = 1'b0;
            end
            if (read && !waitrequest) begin
               m.addr = address;
               m.due  = cyc + int'($urandom_range(lat_max, lat_min));
               mem_q.push_back(m);
            end
            dut_acc = req_read & ~req_waitrequest;

            if (req_readdatavalid != '0) rdv_cnt[phase]++;
            case (phase)
               1: begin
                  if (int'(outstanding) > max_out) max_out = int'(outstanding);
                  if (read) begin
                     read_cnt++;
                     if (first_rd < 0) first_rd = cyc;
                     last_rd = cyc;
                  end
               end
               2: if (req_readdatavalid != '0) begin
                  id = req_readdatavalid[1] ? 1 : 0;
                  if (id == last_ret) alt_bad++;
                  last_ret = id;
               end
               3: begin
                  if (read && waitrequest && address == P3Addr1) hold_cnt++;
                  if (!req_waitrequest[1]) acc1_cyc = cyc;
                  if (!req_waitrequest[0]) acc0_cyc = cyc;
               end
               4: begin
                  if (read && !waitrequest) begin
                     acc_cnt++;
                     if (acc_cnt == 5) fifth_acc_cyc = cyc;
                  end
                  if (readdatavalid && first_ret_cyc < 0) first_ret_cyc = cyc;
               end
               default: ;
            endcase
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      foreach (rdv_cnt[i]) rdv_cnt[i] = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      // Phase 1: lone requester, back-to-back reads queued while still in reset.
      phase = 1;
      for (int i = 0; i < 4; i++) pend_q[0].push_back(32'(i * 8));
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      wait_idle(100, "p1_idle");
      chk("p1_peak_outstanding", 64'(max_out), 64'(3));
      chk("p1_read_cycles", 64'(read_cnt), 64'(4));
      chk("p1_consecutive", 64'(last_rd - first_rd + 1), 64'(4));

      // Phase 2: both requesters saturate, grants alternate.
      phase = 2; lat_min = 2; lat_max = 2;
      for (int i = 0; i < 6; i++) begin
         pend_q[0].push_back(32'h100 + 32'(i * 8));
         pend_q[1].push_back(32'h200 + 32'(i * 8));
      end
      wait_idle(200, "p2_idle");
      chk("p2_alternation", 64'(alt_bad), 64'(0));
      chk("p2_beats", 64'(rdv_cnt[2]), 64'(12));

      // Phase 3: requester 1 stalled 5 cycles, requester 0 arrives during the stall.
      phase = 3;
      @(posedge clk); #2;
      wr_force = 5;
      pend_q[1].push_back(P3Addr1);
      @(posedge clk); #2;
      pend_q[0].push_back(P3Addr0);
      wait_idle(100, "p3_idle");
      chk("p3_hold_cycles", 64'(hold_cnt), 64'(5));
      chk("p3_next_grant", 64'(acc0_cyc - acc1_cyc), 64'(1));

      // Phase 4: memory withholds returns until the tag FIFO fills.
      phase = 4; hold_ret = 1'b1; lat_min = 1; lat_max = 1;
      for (int i = 0; i < 5; i++) pend_q[0].push_back(32'h400 + 32'(i * 8));
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("p4_accepted", 64'(acc_cnt), 64'(4));
      chk("p4_outstanding_full", 64'(outstanding), 64'(4));
      chk("p4_read_blocked", 64'(read), 64'(0));
      @(posedge clk); #2;
      hold_ret = 1'b0;
      wait_idle(100, "p4_idle");
      chk("p4_fifth_after_return", 64'(fifth_acc_cyc - first_ret_cyc), 64'(1));

      // Phase 5: orphan return with nothing outstanding.
      phase = 5;
      orphan_req = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("p5_err_sticky", 64'(err_orphan), 64'(1));
      chk("p5_no_strobe", 64'(rdv_cnt[5]), 64'(0));

      // Phase 6: reset with two reads in flight, stale beats return afterwards.
      @(posedge clk); #2;
      phase = 6; hold_ret = 1'b1; lat_min = 2; lat_max = 2;
      pend_q[1].push_back(32'h600);
      pend_q[1].push_back(32'h608);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("p6_outstanding_before_reset", 64'(outstanding), 64'(2));
      @(posedge clk); #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;
      hold_ret = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("p6_stale_no_strobe", 64'(rdv_cnt[6]), 64'(0));
      chk("p6_err_orphan", 64'(err_orphan), 64'(1));
      @(posedge clk); #2;
      phase = 7;
      pend_q[0].push_back(32'h700);
      wait_idle(100, "p7_idle");
      chk("p7_fresh_strobes", 64'(rdv_cnt[7]), 64'(1));

      // Phase 8: randomized traffic, random stalls/latency, periodic return withholding.
      phase = 8; lat_min = 1; lat_max = 6; wr_prob = 30;
      for (int c = 0; c < 500; c++) begin
         @(posedge clk); #2;
         hold_ret = ((c % 60) < 15);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (pend_q[i].size() < 3 && $urandom_range(99) < 40) begin
               pend_q[i].push_back(32'($urandom_range(4095)) << 3);
            end
         end
      end
      hold_ret = 1'b0; wr_prob = 0;
      wait_idle(500, "p8_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
